// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier producing a 2*DATA_W product into HI/LO.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the sign is reapplied.
module seq_multiplier #(
  parameter int          DATA_W      = 32,
  parameter logic [5:0]  FUNCT_MULT  = 6'b011000,
  parameter logic [5:0]  FUNCT_MULTU = 6'b011001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        funct,
  input  logic              mul_en,
  input  logic              cancel,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   acc;
  logic [CNT_W-1:0]      cnt;
  logic                  negate;

  logic                  op_signed;
  logic                  valid_funct;
  logic                  accept;
  logic [DATA_W:0]       sum;

  // -2^N maps to 2^N, which is representable as an unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic [DATA_W-1:0] r;
    r = (is_signed && v[DATA_W-1]) ? -v : v;
    return r;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] p,
                                                     input logic neg);
    return neg ? (~p + (2*DATA_W)'(1)) : p;
  endfunction

  assign op_signed   = (funct == FUNCT_MULT);
  assign valid_funct = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign accept      = ((state == IDLE) || (state == DONE)) && mul_en && !cancel && valid_funct;
  assign busy        = (state == CALC) || (state == SIGN) || accept;

  // Add keeps the carry so the shifted-in top bit is exact.
  assign sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      negate    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              mcand  <= magnitude(operand_1, op_signed);
              mplier <= magnitude(operand_2, op_signed);
              negate <= op_signed & (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
              acc    <= '0;
              cnt    <= '0;
              state  <= CALC;
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            acc    <= {sum, acc[DATA_W-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) state <= SIGN;
          end
          SIGN: begin
            {result_hi, result_lo} <= apply_sign(acc, negate);
            done                   <= 1'b1;
            state                  <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver queues expected products from a plain
// arithmetic model, a negedge monitor checks every done pulse and result stability.
module tb_seq_multiplier;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam int         LAT     = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  funct = '0;
  logic        mul_en = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] last_prod = '0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  seq_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .funct     (funct),
    .mul_en    (mul_en),
    .cancel    (cancel),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] ref_mul(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (f == F_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Monitor: pops one expectation per done pulse; otherwise results must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", {result_hi, result_lo}, e.prod);
          chk("latency", 64'(cyc), 64'(e.due));
          last_prod = e.prod;
        end
      end else begin
        chk("hold", {result_hi, result_lo}, last_prod);
      end
    end
  end

  // Call at a point between a negedge and the following posedge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    funct     = f;
    operand_1 = a;
    operand_2 = b;
    mul_en    = 1'b1;
    e.prod    = ref_mul(f, a, b);
    e.due     = cyc + 1 + LAT;
    q.push_back(e);
    #1 chk("busy_request", 64'(busy), 64'd1);
    @(negedge clk);
    mul_en    = 1'b0;
    operand_1 = $urandom;
    operand_2 = $urandom;
    funct     = 6'($urandom);
    #1 chk("busy_calc", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic wait_done_pulse();
    int i;
    for (i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
    end
    if (!done) chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(f, a, b);
    wait_done();
  endtask

  logic [5:0]  rf;
  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", 64'(result_hi), 64'd0);
    chk("reset_lo", 64'(result_lo), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F_MULT,  32'd7,         32'hFFFF_FFFD);
    run_op(F_MULT,  32'hFFFF_FFFF, 32'd1);
    run_op(F_MULT,  32'h8000_0000, 32'h8000_0000);
    run_op(F_MULTU, 32'h8000_0000, 32'h8000_0000);
    run_op(F_MULT,  32'h8000_0000, 32'd3);

    // Cancel mid-calculation: no done, results keep the previous product.
    @(negedge clk);
    issue(F_MULT, 32'd1234, 32'd5678);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    q.delete();
    @(negedge clk);
    cancel = 1'b0;
    #1 chk("busy_after_cancel", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Cancel outranks a simultaneous request.
    funct  = F_MULTU;
    mul_en = 1'b1;
    cancel = 1'b1;
    #1 chk("busy_cancel_req", 64'(busy), 64'd0);
    @(negedge clk);
    mul_en = 1'b0;
    cancel = 1'b0;
    #1 chk("busy_after_cancel_req", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Back-to-back: new request presented while in DONE.
    @(negedge clk);
    issue(F_MULTU, 32'd100, 32'd200);
    wait_done_pulse();
    issue(F_MULT, 32'd3, 32'd5);
    wait_done();

    // A non-multiply funct is never accepted.
    @(negedge clk);
    funct  = F_DIV;
    mul_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("busy_div", 64'(busy), 64'd0);
      @(negedge clk);
    end
    mul_en = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    issue(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_prod = '0;
    #1;
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(F_MULT, 32'hFFFF_FFF0, 32'd9);

    // Randomized operations, some issued back-to-back from DONE.
    for (int n = 0; n < 24; n++) begin
      rf = $urandom_range(0, 1) ? F_MULT : F_MULTU;
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'($urandom_range(0, 15));
        default: ra = $urandom;
      endcase
      rb = $urandom_range(0, 3) == 0 ? 32'h7FFF_FFFF : $urandom;
      if (n % 4 == 3 && q.size() > 0) begin
        wait_done_pulse();
        issue(rf, ra, rb);
      end else begin
        wait_done();
        @(negedge clk);
        issue(rf, ra, rb);
      end
    end
    wait_done();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
